systolic_skew_feeder: RTL

Edge feeder for the N×N systolic compute array: accepts one K-slice per beat (column k of A across all rows, row k of B across all columns) via valid/ready and emits diagonally skewed operand streams with matching enables into the array's left and top edges. Row i and column j are delayed by i and j cycles so that both operands, with their enables, reach cell (i,j) in the same cycle, satisfying the cells' requirement that left and above enables agree. It also carries the burst's compute type to the array edge and reports burst completion.

---
 rtl/systolic_skew_feeder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for an N x N systolic array: accepts K-slices and emits
// diagonally skewed operand/enable streams, burst type and completion.
package params;
  typedef logic [7:0] full_type_t;
endpackage

// state  | meaning
// IDLE   | waiting for the first slice of a burst
// STREAM | accepting slices until in_last
// DRAIN  | no accepts; skew chains flush until the last slice leaves lane N-1
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [N*DW-1:0]     a_vec,
  input  logic [N*DW-1:0]     b_vec,
  input  params::full_type_t  type_in,
  output logic [N*DW-1:0]     a_out,
  output logic [N-1:0]        en_left,
  output logic [N*DW-1:0]     b_out,
  output logic [N-1:0]        en_above,
  output params::full_type_t  type_out,
  output logic                busy,
  output logic                done,
  output logic [15:0]         beats
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        beats_q, beats_d;
  params::full_type_t type_q, type_d;
  logic               init_q;
  logic [N-1:0]       last_q;
  logic               accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beats_d  = beats_q;
    type_d   = type_q;
    in_ready = init_q && (state_q != DRAIN);
    accept   = in_valid && in_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          type_d  = type_in;
          beats_d = 16'd1;
          cnt_d   = CW'(N - 1);
          state_d = in_last ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          if (beats_q != 16'hFFFF) beats_d = beats_q + 16'd1;
          if (in_last) begin
            cnt_d   = CW'(N - 1);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // N drain cycles: the last slice reaches lane N-1 in the final one
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beats_q <= '0;
      type_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      type_q  <= type_d;
      init_q  <= 1'b1;
    end
  end

  // last-slice tag travels alongside lane N-1 so done lines up with its enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else begin
      last_q[0] <= accept && in_last;
      for (int s = 1; s < N; s++) last_q[s] <= last_q[s-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW:0] row_q [i+1];
    logic [DW:0] col_q [i+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          row_q[s] <= '0;
          col_q[s] <= '0;
        end
      end else begin
        row_q[0] <= accept ? {1'b1, a_vec[i*DW +: DW]} : '0;
        col_q[0] <= accept ? {1'b1, b_vec[i*DW +: DW]} : '0;
        for (int s = 1; s <= i; s++) begin
          row_q[s] <= row_q[s-1];
          col_q[s] <= col_q[s-1];
        end
      end
    end

    assign a_out[i*DW +: DW] = row_q[i][DW-1:0];
    assign en_left[i]        = row_q[i][DW];
    assign b_out[i*DW +: DW] = col_q[i][DW-1:0];
    assign en_above[i]       = col_q[i][DW];
  end

  assign busy     = (state_q != IDLE);
  assign done     = last_q[N-1];
  assign beats    = beats_q;
  assign type_out = type_q;

endmodule
